// File: rtl/mode_pkg.sv
// rtl/mode_pkg.sv - shared mode index constants, index mapping and blink FSM encoding
package mode_pkg;

  // 2-bit camera mode index as shown by the blink code (pulse count = index + 1)
  localparam logic [1:0] MODE_RGB      = 2'd0;
  localparam logic [1:0] MODE_YUV      = 2'd1;
  localparam logic [1:0] MODE_RGB_TEST = 2'd2;
  localparam logic [1:0] MODE_YUV_TEST = 2'd3;

  // Blink encoder states: dark gap, LED on phase, LED off phase
  typedef enum logic [1:0] {
    S_GAP = 2'd0,
    S_ON  = 2'd1,
    S_OFF = 2'd2
  } blink_state_t;

  // Mode index from the selector outputs: test pattern is the MSB, YUV the LSB
  function automatic logic [1:0] mode_index(input logic rgbmode, input logic testmode);
    return {testmode, ~rgbmode};
  endfunction

endpackage

// File: rtl/mode_blink_timer.sv
// rtl/mode_blink_timer.sv - loadable down-counter with zero flag for phase timing
module mode_blink_timer #(
  parameter int                 c_width   = 4,
  parameter logic [c_width-1:0] c_rst_val = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [c_width-1:0] load_val,
  output logic               zero
);

  logic [c_width-1:0] r_count;

  // Load has priority; otherwise count down and hold at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= c_rst_val;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - c_width'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/mode_blink.sv
// rtl/mode_blink.sv - blink-code encoder showing the camera mode index on one LED
module mode_blink
  import mode_pkg::*;
#(
  parameter logic c_on           = 1'b1,
  parameter int   c_blink_cycles = 12_500_000,
  parameter int   c_gap_cycles   = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rgbmode,
  input  logic       testmode,
  output logic       led,
  output logic       busy,
  output logic       burst_done,
  output logic [1:0] mode_cur
);

  localparam int c_max_cycles = (c_gap_cycles > c_blink_cycles) ? c_gap_cycles : c_blink_cycles;
  localparam int c_w          = $clog2(c_max_cycles);

  localparam logic [c_w-1:0] c_gap_load   = c_w'(c_gap_cycles - 1);
  localparam logic [c_w-1:0] c_blink_load = c_w'(c_blink_cycles - 1);

  blink_state_t   r_state;
  blink_state_t   w_next_state;
  logic [1:0]     r_mode_rg;
  logic [1:0]     r_mode_cur;
  logic [1:0]     r_blink_cnt;
  logic           r_burst_done;

  logic           w_zero;
  logic           w_load;
  logic [c_w-1:0] w_load_val;
  logic           w_latch;
  logic           w_dec;
  logic           w_done;
  logic           w_abort;

  mode_blink_timer #(
    .c_width   (c_w),
    .c_rst_val (c_gap_load)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .zero     (w_zero)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_GAP;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, timer reloads and burst bookkeeping; a mode change mid-burst beats the timer
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = c_blink_load;
    w_latch      = 1'b0;
    w_dec        = 1'b0;
    w_done       = 1'b0;
    w_abort      = (r_mode_rg != r_mode_cur);
    case (r_state)
      S_GAP: begin
        if (w_zero) begin
          w_next_state = S_ON;
          w_load       = 1'b1;
          w_latch      = 1'b1;
        end
      end
      S_ON: begin
        if (w_abort) begin
          w_next_state = S_GAP;
          w_load       = 1'b1;
          w_load_val   = c_gap_load;
        end else if (w_zero) begin
          w_next_state = S_OFF;
          w_load       = 1'b1;
        end
      end
      S_OFF: begin
        if (w_abort) begin
          w_next_state = S_GAP;
          w_load       = 1'b1;
          w_load_val   = c_gap_load;
        end else if (w_zero) begin
          w_load = 1'b1;
          if (r_blink_cnt == 2'd0) begin
            w_next_state = S_GAP;
            w_load_val   = c_gap_load;
            w_done       = 1'b1;
          end else begin
            w_next_state = S_ON;
            w_dec        = 1'b1;
          end
        end
      end
      default: begin
        w_next_state = S_GAP;
        w_load       = 1'b1;
        w_load_val   = c_gap_load;
      end
    endcase
  end

  // Input sampling, per-burst mode latch, remaining pulse count and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_rg    <= MODE_RGB;
      r_mode_cur   <= MODE_RGB;
      r_blink_cnt  <= 2'd0;
      r_burst_done <= 1'b0;
    end else begin
      r_mode_rg    <= mode_index(rgbmode, testmode);
      r_burst_done <= w_done;
      if (w_latch) begin
        r_mode_cur  <= r_mode_rg;
        r_blink_cnt <= r_mode_rg;
      end else if (w_dec) begin
        r_blink_cnt <= r_blink_cnt - 2'd1;
      end
    end
  end

  assign led        = (r_state == S_ON) ? c_on : ~c_on;
  assign busy       = (r_state == S_ON) || (r_state == S_OFF);
  assign burst_done = r_burst_done;
  assign mode_cur   = r_mode_cur;

endmodule

// File: tb/tb_mode_blink.sv
// tb/tb_mode_blink.sv - randomized bench for mode_blink against a timeline reference model
module tb_mode_blink;

  localparam int B = 4;
  localparam int G = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rgbmode = 1'b1;
  logic       testmode = 1'b0;
  logic       led_h, busy_h, done_h;
  logic [1:0] cur_h;
  logic       led_l, busy_l, done_l;
  logic [1:0] cur_l;

  always #5 clk = ~clk;

  mode_blink #(.c_on(1'b1), .c_blink_cycles(B), .c_gap_cycles(G)) u_dut_hi (
    .clk(clk), .rst(rst), .rgbmode(rgbmode), .testmode(testmode),
    .led(led_h), .busy(busy_h), .burst_done(done_h), .mode_cur(cur_h)
  );

  mode_blink #(.c_on(1'b0), .c_blink_cycles(B), .c_gap_cycles(G)) u_dut_lo (
    .clk(clk), .rst(rst), .rgbmode(rgbmode), .testmode(testmode),
    .led(led_l), .busy(busy_l), .burst_done(done_l), .mode_cur(cur_l)
  );

  // Reference: a queue of per-cycle expected outputs, refilled one whole gap or burst at a time
  typedef struct {
    bit on;
    bit busy;
    bit last_gap;
    bit last_burst;
  } seg_t;

  seg_t       seq[$];
  logic [1:0] m_rg;
  logic [1:0] m_cur;
  bit         m_done;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_gap();
    for (int i = 0; i < G; i++) seq.push_back('{1'b0, 1'b0, (i == G - 1), 1'b0});
  endtask

  task automatic push_burst(input int pulses);
    for (int p = 0; p < pulses; p++) begin
      for (int i = 0; i < B; i++) seq.push_back('{1'b1, 1'b1, 1'b0, 1'b0});
      for (int i = 0; i < B; i++) seq.push_back('{1'b0, 1'b1, 1'b0, (p == pulses - 1) && (i == B - 1)});
    end
  endtask

  task automatic model_reset();
    seq.delete();
    push_gap();
    m_rg   = 2'd0;
    m_cur  = 2'd0;
    m_done = 1'b0;
  endtask

  // One clock edge of the reference, using the mode that was registered before the edge
  task automatic model_step();
    seg_t e;
    if (rst) begin
      model_reset();
      return;
    end
    e = seq.pop_front();
    m_done = 1'b0;
    if (e.busy && (m_rg != m_cur)) begin
      seq.delete();
      push_gap();
    end else if (e.last_gap) begin
      m_cur = m_rg;
      push_burst(int'(m_cur) + 1);
    end else if (e.last_burst) begin
      m_done = 1'b1;
      push_gap();
    end
    m_rg = {testmode, ~rgbmode};
  endtask

  task automatic check_outputs();
    chk("led_hi",  led_h,  seq[0].on);
    chk("led_lo",  led_l,  !seq[0].on);
    chk("busy_hi", busy_h, seq[0].busy);
    chk("busy_lo", busy_l, seq[0].busy);
    chk("done_hi", done_h, m_done);
    chk("done_lo", done_l, m_done);
    chk("cur_hi",  cur_h,  m_cur);
    chk("cur_lo",  cur_l,  m_cur);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_mode(input logic [1:0] m);
    testmode = m[1];
    rgbmode  = ~m[0];
  endtask

  // Assert reset between edges and check the outputs clear without a clock
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_led_hi", led_h, 1'b0);
    chk("arst_led_lo", led_l, 1'b1);
    chk("arst_busy",   busy_h, 1'b0);
    chk("arst_done",   done_h, 1'b0);
    chk("arst_cur",    cur_h, 2'd0);
    model_reset();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int k;
    model_reset();
    @(negedge clk);
    check_outputs();
    cycle();
    rst = 1'b0;

    // First rise after release: the release cycle counts as cycle 1
    k = 0;
    while (!led_h && k < 40) begin
      cycle();
      k++;
    end
    chk("first_rise_cycle", k + 1, 11);

    run(40);
    set_mode(2'd3);
    run(90);

    // Switch 0 -> 2 during the second ON cycle of a burst
    set_mode(2'd0);
    run(40);
    k = 0;
    while (!led_h && k < 40) begin
      cycle();
      k++;
    end
    chk("wait_on", led_h, 1'b1);
    cycle();
    set_mode(2'd2);
    run(70);

    // Reset in the middle of a mode 3 burst
    set_mode(2'd3);
    run(50);
    async_reset();
    run(40);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) set_mode(2'($urandom_range(0, 3)));
      if ($urandom_range(0, 399) == 0) async_reset();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mode_blink.md
Name: mode_blink

Overview:
- Blink-code encoder for the current camera mode; it is the user-facing inverse of the push-button mode selector.
- Takes the rgbmode/testmode pair produced by the mode selector and shows it on one LED as a repeating burst of N pulses, with N = mode index + 1, separated by a long dark gap.
- Sits in the top level beside the mode selector and drives a board LED. Same 50 MHz clock domain.

Parameters:
- c_on, 1'b1, LED active level (1 = active-high LED, 0 = active-low).
- c_blink_cycles, 12_500_000, length of each ON phase and each OFF phase in clk cycles (250 ms at 50 MHz). Must be ≥ 2.
- c_gap_cycles, 50_000_000, length of the dark gap between bursts in clk cycles (1 s). Must be ≥ 2.

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous, active-high reset
- rgbmode  input  1  1 = RGB, 0 = YUV (from the mode selector)
- testmode  input  1  1 = camera test pattern
- led  output  1  blink-code LED, polarity set by c_on
- busy  output  1  high while a burst (ON/OFF phases) is in progress
- burst_done  output  1  one-cycle pulse when a full burst completes
- mode_cur  output  2  mode index latched for the current burst

Behaviour:
- Mode index = {testmode, ~rgbmode}:
  - 0 = RGB normal
  - 1 = YUV normal
  - 2 = RGB test
  - 3 = YUV test
- Inputs are registered once (mode_rg); all decisions use mode_rg.
- Reset (async, active-high):
  - state = S_GAP, timer = c_gap_cycles-1, blink count = 0, mode_cur = 0, mode_rg = 0.
  - led = ~c_on, busy = 0, burst_done = 0.
- FSM states:
  - S_GAP: led = ~c_on, busy = 0. Timer counts down. At timer == 0: latch mode_cur <= mode_rg, blink count <= mode_rg, timer <= c_blink_cycles-1, go to S_ON.
  - S_ON: led = c_on, busy = 1. At timer == 0: timer <= c_blink_cycles-1, go to S_OFF.
  - S_OFF: led = ~c_on, busy = 1. At timer == 0:
    - If blink count == 0: pulse burst_done for 1 cycle, timer <= c_gap_cycles-1, go to S_GAP.
    - Else: decrement blink count, timer <= c_blink_cycles-1, go to S_ON.
- Phase lengths are exact:
  - S_GAP = c_gap_cycles cycles; S_ON and S_OFF = c_blink_cycles cycles each.
  - Burst length = 2·(mode_cur+1)·c_blink_cycles cycles.
  - The first S_GAP after reset is also c_gap_cycles cycles long.
- Mode change:
  - If mode_rg differs from mode_cur during S_ON or S_OFF, the burst aborts on the next clk edge: go to S_GAP, timer <= c_gap_cycles-1, led off, no burst_done.
  - A change during S_GAP needs no action; the new mode is latched at the end of the gap.
  - The abort compare has priority over a coincident timer == 0 event.
- Outputs are registered. led follows the state with 0 extra latency (decoded from the registered state).
- Counter width = $clog2(max(c_gap_cycles, c_blink_cycles)); the timer never underflows because it is always reloaded at 0.
- Reset mid-burst returns everything to the reset values immediately.

Decomposition:
- Shared package mode_pkg holds:
  - the 2-bit mode index constants (MODE_RGB, MODE_YUV, MODE_RGB_TEST, MODE_YUV_TEST);
  - the index mapping from rgbmode/testmode;
  - the FSM state encoding (S_GAP, S_ON, S_OFF).
- mode_sel is updated to use the same package.
- One sub-module is natural: mode_blink_timer. It is a loadable down-counter with parameter width, inputs load/load_val, and output zero.

Test Plan (c_blink_cycles=4, c_gap_cycles=10, c_on=1):
- Reset, mode 0 (rgbmode=1, testmode=0) -> led 0 for 10 cycles, 1 for 4, 0 for 4; burst_done pulses once on the 18th cycle; busy high for 8 cycles; pattern repeats every 18 cycles.
- Mode 3 (rgbmode=0, testmode=1) -> after the 10-cycle gap, 4 pulses of 4 cycles high / 4 low; busy high for 32 cycles; mode_cur = 3; one burst_done.
- Mode 0 → 2 change during the 2nd cycle of S_ON -> led drops within 2 cycles of the input change (1 register + 1 transition); no burst_done; 10-cycle gap; then 3 pulses.
- Mode change during S_GAP -> gap length unchanged (10 cycles); the following burst uses the new count.
- Assert rst mid-burst (S_OFF of pulse 2, mode 3) -> led = 0, busy = 0 and mode_cur = 0 asynchronously; after release, the first rise occurs at cycle 11.
- c_on=0, mode 1 -> led idles at 1; two 4-cycle low pulses per burst; timing identical to the c_on=1 case.
